// File: rtl/gl_ibram_arbiter_pkg.sv
// Shared definitions for the instruction/command BRAM arbiter.
// Holds the FSM state codes, the read-return tag, the burst limit and the
// byte-to-word address shift, plus the decode burst length clamp.
package gl_ibram_arbiter_pkg;

  // Longest decode burst (LOADMATRIX payload), in words.
  localparam int IBRAM_BURST_MAX = 16;

  // Byte address -> word address: drop the two byte-lane bits.
  localparam int WORD_SHIFT = 2;

  // Arbiter FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Owner of the read data returning from the BRAM on the next cycle.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DEC   = 2'd2
  } ret_tag_t;

  // A zero-length request still moves one word; anything longer than the
  // payload limit is cut down to the limit.
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int max_len);
    if (len == 5'd0)
      return 5'd1;
    if (int'(len) > max_len)
      return 5'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/gl_burst_counter.sv
// Decode burst address/length tracker.
// Latency: load in the grant cycle (first word is issued by the arbiter
//   directly), then one issue per advance; last flags the final word.
// Backpressure: none; advance is the only pacing input.
// Ports: load/load_addr/load_len capture a burst, advance steps it,
//   addr/issue/last describe the word to issue in the current cycle.
module gl_burst_counter #(
  parameter int AW = 10,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_len,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          issue,
  output logic          last
);

  logic [LW-1:0] remaining;
  logic          wrap;

  // Top of the BRAM: next word address rolls over to zero.
  assign wrap  = (addr == {AW{1'b1}});
  assign issue = (remaining != '0);
  assign last  = (remaining == LW'(1));

  // The grant cycle already consumed word 0, so we hold start+1 and L-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr + 1'b1;
      remaining <= load_len - 1'b1;
    end else if (advance && issue) begin
      addr      <= wrap ? '0 : addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: rtl/gl_ibram_arbiter.sv
// Arbiter sharing one single-port BRAM between host writes, decode read
//   bursts and single-word instruction fetches.
// Latency: grant and BRAM command are combinational; read data returns one
//   cycle after issue, steered by a registered return tag.
// Backpressure: fetch is stalled when not granted; a running decode burst
//   cannot be pre-empted; host waits (no ack) until granted.
// Ports: host_* write side, fetch_* read side, dec_* burst side, bram_* to
//   the primitive.
import gl_ibram_arbiter_pkg::*;

module gl_ibram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BRAM_AW   = 10,
  parameter int BURST_MAX = IBRAM_BURST_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_req,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               host_ack,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_stall,
  output logic               fetch_valid,
  output logic [DATA_W-1:0]  fetch_data,
  input  logic               dec_req,
  input  logic [ADDR_W-1:0]  dec_addr,
  input  logic [4:0]         dec_len,
  output logic               dec_busy,
  output logic               dec_valid,
  output logic               dec_last,
  output logic [DATA_W-1:0]  dec_data,
  output logic               bram_en,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [DATA_W-1:0]  bram_wdata,
  input  logic [DATA_W-1:0]  bram_rdata
);

  localparam int WA_HI = BRAM_AW + WORD_SHIFT - 1;

  logic [0:0]         state;
  ret_tag_t           tag_q;
  logic               last_q;
  logic               fetch_first;

  logic [BRAM_AW-1:0] host_word, fetch_word, dec_word, cnt_addr;
  logic [4:0]         dec_len_eff;
  logic               in_idle, dec_ok;
  logic               host_grant, dec_grant, fetch_grant;
  logic               burst_issue, cnt_issue, cnt_last, last_issue;
  logic               unused_addr_bits;

  assign host_word   = host_addr[WA_HI:WORD_SHIFT];
  assign fetch_word  = fetch_addr[WA_HI:WORD_SHIFT];
  assign dec_word    = dec_addr[WA_HI:WORD_SHIFT];
  assign dec_len_eff = clamp_len(dec_len, BURST_MAX);

  // Byte-lane and out-of-range address bits carry no meaning for the BRAM.
  assign unused_addr_bits = ^{host_addr[ADDR_W-1:WA_HI+1],  host_addr[WORD_SHIFT-1:0],
                              fetch_addr[ADDR_W-1:WA_HI+1], fetch_addr[WORD_SHIFT-1:0],
                              dec_addr[ADDR_W-1:WA_HI+1],   dec_addr[WORD_SHIFT-1:0]};

  // Grants are suppressed while reset is held so nothing reaches the BRAM.
  assign in_idle = reset && (state == ST_IDLE);
  // A new burst is refused until the previous one has fully returned.
  assign dec_ok  = dec_req && !dec_busy;

  always_comb begin
    host_grant  = 1'b0;
    dec_grant   = 1'b0;
    fetch_grant = 1'b0;
    if (in_idle) begin
      if (fetch_first) begin
        // Fetch was starved by the burst just finished: let it go first.
        if (fetch_req)     fetch_grant = 1'b1;
        else if (host_req) host_grant  = 1'b1;
        else if (dec_ok)   dec_grant   = 1'b1;
      end else begin
        if (host_req)       host_grant  = 1'b1;
        else if (dec_ok)    dec_grant   = 1'b1;
        else if (fetch_req) fetch_grant = 1'b1;
      end
    end
  end

  gl_burst_counter #(.AW(BRAM_AW), .LW(5)) u_burst_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (dec_grant),
    .load_addr (dec_word),
    .load_len  (dec_len_eff),
    .advance   (burst_issue),
    .addr      (cnt_addr),
    .issue     (cnt_issue),
    .last      (cnt_last)
  );

  assign burst_issue = reset && (state == ST_BURST) && cnt_issue;
  // Final word of a burst, whether it is a one-word grant or a BURST issue.
  assign last_issue  = (dec_grant && (dec_len_eff == 5'd1)) || (burst_issue && cnt_last);

  always_comb begin
    bram_en    = host_grant || dec_grant || fetch_grant || burst_issue;
    bram_we    = host_grant;
    bram_wdata = host_grant ? host_wdata : '0;
    bram_addr  = '0;
    if (burst_issue)      bram_addr = cnt_addr;
    else if (host_grant)  bram_addr = host_word;
    else if (dec_grant)   bram_addr = dec_word;
    else if (fetch_grant) bram_addr = fetch_word;
  end

  assign host_ack    = host_grant;
  assign fetch_stall = fetch_req && !fetch_grant;

  assign fetch_valid = (tag_q == TAG_FETCH);
  assign dec_valid   = (tag_q == TAG_DEC);
  assign dec_last    = dec_valid && last_q;
  assign fetch_data  = fetch_valid ? bram_rdata : '0;
  assign dec_data    = dec_valid ? bram_rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      tag_q       <= TAG_NONE;
      last_q      <= 1'b0;
      dec_busy    <= 1'b0;
      fetch_first <= 1'b0;
    end else begin
      if (fetch_grant)                    tag_q <= TAG_FETCH;
      else if (dec_grant || burst_issue)  tag_q <= TAG_DEC;
      else                                tag_q <= TAG_NONE;

      last_q <= last_issue;

      if (dec_grant && (dec_len_eff != 5'd1)) state <= ST_BURST;
      else if (burst_issue && cnt_last)       state <= ST_IDLE;

      if (dec_grant)     dec_busy <= 1'b1;
      else if (dec_last) dec_busy <= 1'b0;

      if (last_issue)                     fetch_first <= 1'b1;
      else if (fetch_grant || !fetch_req) fetch_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gl_ibram_arbiter.sv
module tb_gl_ibram_arbiter;

  logic        clk;
  logic        reset;
  logic        host_req;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        dec_req;
  logic [31:0] dec_addr;
  logic [4:0]  dec_len;
  logic        dec_busy;
  logic        dec_valid;
  logic        dec_last;
  logic [31:0] dec_data;
  logic        bram_en;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;

  gl_ibram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .dec_req     (dec_req),
    .dec_addr    (dec_addr),
    .dec_len     (dec_len),
    .dec_busy    (dec_busy),
    .dec_valid   (dec_valid),
    .dec_last    (dec_last),
    .dec_data    (dec_data),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_wdata  (bram_wdata),
    .bram_rdata  (bram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port BRAM model, 1-cycle read latency.
  logic [31:0] mem [0:1023];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr];
    end
  end

  // Bench-side expected memory contents.
  logic [31:0] shadow [0:1023];

  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 fetch, 2 decode
    logic [31:0] data;
    logic        last;
  } ret_t;
  ret_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check the combinational command for the current cycle and queue the
  // return expected one cycle later.
  task automatic issue_chk(input string tag, input logic en, input logic we,
                           input logic [9:0] a, input logic stall,
                           input logic [1:0] kind, input logic last);
    ret_t e;
    #1;
    chk({tag, ".en"},    32'(bram_en),     32'(en));
    chk({tag, ".we"},    32'(bram_we),     32'(we));
    chk({tag, ".ack"},   32'(host_ack),    32'(we));
    chk({tag, ".stall"}, 32'(fetch_stall), 32'(stall));
    if (en) chk({tag, ".addr"}, 32'(bram_addr), 32'(a));
    if (we) begin
      chk({tag, ".wdata"}, bram_wdata, host_wdata);
      shadow[a] = host_wdata;
    end
    e.kind = kind;
    e.data = (kind != 2'd0) ? shadow[a] : 32'd0;
    e.last = last;
    sb.push_back(e);
  endtask

  // Advance one clock and compare the returned read against the scoreboard.
  task automatic tick(input string tag);
    ret_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      e.kind = 2'd0; e.data = 32'd0; e.last = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, ".fvalid"}, 32'(fetch_valid), 32'(e.kind == 2'd1));
    chk({tag, ".dvalid"}, 32'(dec_valid),   32'(e.kind == 2'd2));
    chk({tag, ".dlast"},  32'(dec_last),    32'((e.kind == 2'd2) && e.last));
    if (e.kind == 2'd1) chk({tag, ".fdata"}, fetch_data, e.data);
    if (e.kind == 2'd2) chk({tag, ".ddata"}, dec_data,   e.data);
  endtask

  task automatic burst(input string tag, input logic [31:0] a, input logic [4:0] len, input int n);
    logic [9:0] wa;
    wa = a[11:2];
    dec_req = 1'b1; dec_addr = a; dec_len = len;
    for (int k = 0; k < n; k++) begin
      if (k == 1) dec_req = 1'b0;
      issue_chk(tag, 1'b1, 1'b0, wa + 10'(k), 1'b0, 2'd2, k == n - 1);
      tick(tag);
    end
    dec_req = 1'b0;
    issue_chk({tag, "_idle"}, 1'b0, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    tick({tag, "_idle"});
    issue_chk({tag, "_idle2"}, 1'b0, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    tick({tag, "_idle2"});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 32'hC0DE_0000 | 32'(i);
    reset = 1'b0; init_mem = 1'b1;
    host_req = 1'b0; host_addr = '0; host_wdata = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    dec_req = 1'b0; dec_addr = '0; dec_len = '0;
    @(posedge clk); #1;
    init_mem = 1'b0;

    // Requests during reset must not reach the BRAM.
    fetch_req = 1'b1; host_req = 1'b1;
    #1;
    chk("rst.en_gated", 32'(bram_en), 32'd0);
    @(posedge clk); #1;
    fetch_req = 1'b0; host_req = 1'b0;
    #1;
    chk("rst.fvalid", 32'(fetch_valid), 32'd0);
    chk("rst.dvalid", 32'(dec_valid),   32'd0);
    chk("rst.dlast",  32'(dec_last),    32'd0);
    chk("rst.busy",   32'(dec_busy),    32'd0);
    chk("rst.ack",    32'(host_ack),    32'd0);
    chk("rst.en",     32'(bram_en),     32'd0);
    chk("rst.we",     32'(bram_we),     32'd0);
    chk("rst.fdata",  fetch_data,       32'd0);
    chk("rst.ddata",  dec_data,         32'd0);
    reset = 1'b1;

    // Fetch only: words 0, 1, 2.
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 32'(4 * i);
      issue_chk("fetch", 1'b1, 1'b0, 10'(i), 1'b0, 2'd1, 1'b0);
      tick("fetch");
    end
    fetch_req = 1'b0;
    issue_chk("fetch_idle", 1'b0, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    tick("fetch_idle");

    // Host beats fetch; fetch then reads the freshly written word.
    host_req = 1'b1; host_addr = 32'h10; host_wdata = 32'h1234_5678;
    fetch_req = 1'b1; fetch_addr = 32'h10;
    issue_chk("hvf_host", 1'b1, 1'b1, 10'd4, 1'b1, 2'd0, 1'b0);
    tick("hvf_host");
    host_req = 1'b0;
    issue_chk("hvf_fetch", 1'b1, 1'b0, 10'd4, 1'b0, 2'd1, 1'b0);
    tick("hvf_fetch");

    // 16-word burst with fetch and (later) host waiting.
    dec_req = 1'b1; dec_addr = 32'h40; dec_len = 5'd16;
    fetch_req = 1'b1; fetch_addr = 32'h8;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) dec_req = 1'b0;
      if (k == 5) begin host_req = 1'b1; host_addr = 32'h20; host_wdata = 32'hBEEF_0001; end
      issue_chk("b16", 1'b1, 1'b0, 10'(16 + k), 1'b1, 2'd2, k == 15);
      if (k > 0) chk("b16.busy", 32'(dec_busy), 32'd1);
      tick("b16");
    end
    issue_chk("b16_fetch_first", 1'b1, 1'b0, 10'd2, 1'b0, 2'd1, 1'b0);
    tick("b16_fetch_first");
    fetch_req = 1'b0;
    issue_chk("b16_host", 1'b1, 1'b1, 10'd8, 1'b0, 2'd0, 1'b0);
    chk("b16.busy_fall", 32'(dec_busy), 32'd0);
    tick("b16_host");
    host_req = 1'b0;

    // Wrap and length clamps.
    burst("wrap",  32'hFF8, 5'd4,  4);
    burst("len0",  32'h100, 5'd0,  1);
    burst("len20", 32'h200, 5'd20, 16);

    // Reset at the 5th word of a 16-word burst.
    dec_req = 1'b1; dec_addr = 32'h0; dec_len = 5'd16;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) dec_req = 1'b0;
      issue_chk("rmb", 1'b1, 1'b0, 10'(k), 1'b0, 2'd2, 1'b0);
      tick("rmb");
    end
    reset = 1'b0;
    issue_chk("rmb_rst", 1'b0, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    tick("rmb_rst");
    chk("rmb.busy", 32'(dec_busy), 32'd0);
    reset = 1'b1;
    issue_chk("rmb_after", 1'b0, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    tick("rmb_after");

    // Back-to-back: 3-word burst then fetch.
    fetch_req = 1'b1; fetch_addr = 32'hC;
    dec_req = 1'b1; dec_addr = 32'h80; dec_len = 5'd3;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) dec_req = 1'b0;
      issue_chk("b2b", 1'b1, 1'b0, 10'(32 + k), 1'b1, 2'd2, k == 2);
      tick("b2b");
    end
    issue_chk("b2b_fetch", 1'b1, 1'b0, 10'd3, 1'b0, 2'd1, 1'b0);
    tick("b2b_fetch");
    fetch_req = 1'b0;
    issue_chk("b2b_idle", 1'b0, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0);
    tick("b2b_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gl_ibram_arbiter.md
Name: gl_ibram_arbiter

Overview:
- Shares the single-port command/instruction BRAM among three requesters: the host loader (writes), the decode operand reader (multi-word read bursts) and instruction fetch (single-word reads).
- Sits between the fetch stage, the decode stage and the BRAM primitive.
- Generates the fetch stall so fetch and decode never collide on the BRAM port.

Parameters:
- ADDR_W, 32, byte-address width presented by requesters.
- DATA_W, 32, BRAM word width.
- BRAM_AW, 10, BRAM word-address width; BRAM word address = byte_addr[BRAM_AW+1:2].
- BURST_MAX, 16, maximum decode burst length in words (LOADMATRIX payload).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- host_req  in  1  host write request.
- host_addr  in  ADDR_W  host byte address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  write performed this cycle.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_stall  out  1  fetch not granted this cycle.
- fetch_valid  out  1  fetch_data valid.
- fetch_data  out  DATA_W  fetched word.
- dec_req  in  1  decode burst request.
- dec_addr  in  ADDR_W  burst start byte address.
- dec_len  in  5  burst length in words.
- dec_busy  out  1  burst accepted and not yet fully delivered.
- dec_valid  out  1  dec_data valid.
- dec_last  out  1  final word of burst.
- dec_data  out  DATA_W  burst word.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  BRAM_AW  BRAM word address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data; 1-cycle latency.

Behaviour:
- **Reset** (reset==0 at posedge):
  - state=IDLE, burst counters cleared, fetch_first flag cleared.
  - host_ack, fetch_valid, dec_valid, dec_last, dec_busy, bram_en, bram_we all 0.
  - fetch_data and dec_data = 0.
  - An in-flight burst or read is aborted; BRAM data returning in the next cycle is discarded.
- **States:** IDLE, BURST.
- **IDLE arbitration** (combinational grant each cycle):
  - Base priority: host > dec > fetch.
  - When fetch_first=1: fetch > host > dec. fetch_first is set when a burst completes and cleared when fetch is granted or fetch_req=0.
- **Host grant:**
  - bram_en=1, bram_we=1, bram_addr=host word address, bram_wdata=host_wdata, host_ack=1 in the same cycle.
  - Writes take one cycle; no read data is returned.
- **Fetch grant:**
  - bram_en=1, bram_we=0, fetch_stall=0.
  - fetch_valid=1 with fetch_data=bram_rdata on the next cycle.
  - fetch_stall = fetch_req & ~fetch_grant, combinational.
  - fetch_stall=0 when fetch_req=0.
- **Decode grant:**
  - Latch start word address and length L into registers; enter BURST.
  - The first read issues in the grant cycle.
  - dec_len=0 is treated as 1; dec_len>BURST_MAX is clamped to BURST_MAX.
- **BURST:**
  - One read per cycle at consecutive word addresses, L reads total.
  - Word address wraps modulo 2^BRAM_AW.
  - Non-preemptible: host and fetch wait, and fetch_stall=1 whenever fetch_req=1.
  - Return IDLE after the L-th issue.
- **Decode return:**
  - dec_valid follows each issue by exactly 1 cycle.
  - dec_last accompanies the L-th word.
  - dec_busy rises the cycle after grant and falls the cycle after dec_last.
  - dec_req is ignored while dec_busy=1 or in BURST.
- **Back-to-back operation:** a new grant may occur in the cycle after the last burst issue, i.e. the same cycle the last word returns. Read-return pipelining must not drop or mis-tag data.
- **Return tagging:** a 1-cycle registered tag (NONE/FETCH/DEC) steers bram_rdata to the right requester.
- **Idle cycles:** bram_en=0 when nothing is granted.

Decomposition:
- **Shared package:** state encoding, return-tag encoding (NONE/FETCH/DEC), BURST_MAX, and the byte-to-word address conversion constant (shift 2).
- **Sub-module gl_burst_counter:** holds the burst address/remaining count and produces issue, last and wrap.
- The arbitration logic stays in the top module.

Test Plan:
- **Fetch only:** fetch_req=1 at byte addr 0x0, 0x4, 0x8 → fetch_stall=0; bram_addr=0,1,2; fetch_valid each next cycle with matching data.
- **Host vs fetch:** host_req and fetch_req both 1 → host_ack=1, fetch_stall=1, bram_we=1 in that cycle; fetch granted the following cycle.
- **16-word burst:** dec_req with addr 0x40, len=16 → bram_addr 16..31 over 16 cycles; dec_valid for 16 cycles; dec_last on the 16th; fetch_stall=1 throughout; after the burst, fetch is granted before a pending host_req.
- **Wrap and clamp:** BRAM_AW=10, dec_addr=0xFF8, len=4 → bram_addr 1022, 1023, 0, 1. Separately, len=0 → 1 word; len=20 → 16 words.
- **Reset mid-burst:** reset=0 at the 5th word of a 16-word burst → next cycle all valids=0, dec_busy=0, bram_en=0; no dec_valid for the discarded read.
- **Back-to-back:** burst len=3 immediately followed by fetch_req → fetch issue the cycle after the 3rd read; dec_last and fetch_valid land on consecutive cycles with correct data.
